// File: rtl/sass_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sass_pkg : shared keypad width, key vector type and prescaler defaults
// Revision : 1.0
// ----------------------------------------------------------------------------
package sass_pkg;

  localparam int NUM_KEYS           = 15;
  localparam int DEFAULT_TICK_DIV   = 10000;
  localparam int DEFAULT_STABLE_CNT = 4;
  localparam int KEY_CNT_W          = 4;

  typedef logic [NUM_KEYS-1:0] keyvec_t;

endpackage : sass_pkg
`default_nettype wire

// File: rtl/key_debounce_cell.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_debounce_cell : per-key tick-sampled debounce filter with edge strobes
// Revision : 1.0
// ----------------------------------------------------------------------------
module key_debounce_cell
  import sass_pkg::*;
#(
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT
) (
  input  logic hwclk,
  input  logic rst,
  input  logic tick_i,
  input  logic sync_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [KEY_CNT_W-1:0] C_CNT_LAST = KEY_CNT_W'(STABLE_CNT - 1);

  logic [KEY_CNT_W-1:0] cnt_q, cnt_d;
  logic                 key_q, key_d;
  logic                 prev_q;
  logic                 press_q;
  logic                 release_q;

  // Any agreeing sample restarts the run, so only an unbroken streak toggles.
  always_comb begin
    cnt_d = cnt_q;
    key_d = key_q;
    if (tick_i) begin
      if (sync_i == key_q) begin
        cnt_d = '0;
      end else if (cnt_q == C_CNT_LAST) begin
        key_d = ~key_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + KEY_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      cnt_q     <= '0;
      key_q     <= 1'b0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      prev_q    <= key_q;
      press_q   <= key_q & ~prev_q;
      release_q <= ~key_q & prev_q;
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : key_debounce_cell
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_debounce : keypad synchroniser, shared tick prescaler and debounce bank
// Revision : 1.0
// ----------------------------------------------------------------------------
module key_debounce #(
  parameter int NUM_KEYS   = sass_pkg::NUM_KEYS,
  parameter int TICK_DIV   = sass_pkg::DEFAULT_TICK_DIV,
  parameter int STABLE_CNT = sass_pkg::DEFAULT_STABLE_CNT
) (
  input  logic                hwclk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic [NUM_KEYS-1:0] press_o,
  output logic [NUM_KEYS-1:0] release_o,
  output logic                any_key_o,
  output logic [3:0]          num_pressed_o,
  output logic                tick_o
);

  import sass_pkg::*;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_PRESC_LAST = CNT_W'(TICK_DIV - 1);

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [CNT_W-1:0]    presc_q, presc_d;
  logic                tick_w;
  logic                tick_q;
  logic [3:0]          num_q, num_d;

  assign tick_w  = (presc_q == C_PRESC_LAST);
  assign presc_d = tick_w ? '0 : presc_q + CNT_W'(1);

  always_comb begin
    num_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      num_d = num_d + 4'(keys_o[k]);
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      num_q   <= '0;
    end else begin
      sync1_q <= keys_i;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      tick_q  <= tick_w;
      num_q   <= num_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_cell #(
        .STABLE_CNT (STABLE_CNT)
      ) u_cell (
        .hwclk     (hwclk),
        .rst       (rst),
        .tick_i    (tick_w),
        .sync_i    (sync2_q[i]),
        .key_o     (keys_o[i]),
        .press_o   (press_o[i]),
        .release_o (release_o[i])
      );
    end
  endgenerate

  assign any_key_o     = |keys_o;
  assign num_pressed_o = num_q;
  assign tick_o        = tick_q;

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_key_debounce : directed bench for key_debounce (TICK_DIV=4, STABLE_CNT=3)
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int NK = 15;

  logic          hwclk = 1'b0;
  logic          rst   = 1'b1;
  logic [NK-1:0] keys_i = '0;
  logic [NK-1:0] keys_o;
  logic [NK-1:0] press_o;
  logic [NK-1:0] release_o;
  logic          any_key_o;
  logic [3:0]    num_pressed_o;
  logic          tick_o;

  int tests_run    = 0;
  int tests_failed = 0;

  key_debounce #(
    .NUM_KEYS   (NK),
    .TICK_DIV   (4),
    .STABLE_CNT (3)
  ) dut (
    .hwclk         (hwclk),
    .rst           (rst),
    .keys_i        (keys_i),
    .keys_o        (keys_o),
    .press_o       (press_o),
    .release_o     (release_o),
    .any_key_o     (any_key_o),
    .num_pressed_o (num_pressed_o),
    .tick_o        (tick_o)
  );

  always #5 hwclk = ~hwclk;

  // Advance one active edge; outputs are then read at the falling edge.
  task automatic step();
    @(posedge hwclk);
    @(negedge hwclk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    keys_i = '0;
    repeat (3) step();
    tests_run++;
    if ({keys_o, press_o, release_o, any_key_o, num_pressed_o, tick_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: keys=%h press=%h rel=%h any=%b num=%0d tick=%b, required all 0",
               keys_o, press_o, release_o, any_key_o, num_pressed_o, tick_o);
    end
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      tests_run++;
      if (tick_o !== ((j % 4) == 3)) begin
        tests_failed++;
        $display("FAIL tick_period: cycle %0d tick_o=%b, required %b", j, tick_o, (j % 4) == 3);
      end
    end
  endtask

  task automatic test_press();
    bit found = 0;
    keys_i[5] = 1'b1;
    for (int n = 0; n < 14 && !found; n++) begin
      step();
      if (keys_o[5] === 1'b1) found = 1;
      else begin
        tests_run++;
        if (press_o !== '0) begin
          tests_failed++;
          $display("FAIL press_early: press_o=%h before keys_o rose, required 0", press_o);
        end
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL press_latency: keys_o[5]=%b after 14 cycles, required 1", keys_o[5]);
    end
    tests_run++;
    if (keys_o !== 15'h0020 || any_key_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_level: keys_o=%h any=%b, required 0020/1", keys_o, any_key_o);
    end
    tests_run++;
    if (press_o !== '0 || num_pressed_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL press_lag: press_o=%h num=%0d, required 0000/0", press_o, num_pressed_o);
    end
    step();
    tests_run++;
    if (press_o !== 15'h0020 || release_o !== '0 || num_pressed_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL press_strobe: press=%h rel=%h num=%0d, required 0020/0000/1",
               press_o, release_o, num_pressed_o);
    end
    step();
    tests_run++;
    if (press_o !== '0) begin
      tests_failed++;
      $display("FAIL press_width: press_o=%h, required 0000", press_o);
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 40; c++) begin
      if ((c % 3) == 0) keys_i[0] = ~keys_i[0];
      step();
      tests_run++;
      if (keys_o[0] !== 1'b0 || press_o[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL bounce_reject: cycle %0d keys_o[0]=%b press_o[0]=%b, required 0/0",
                 c, keys_o[0], press_o[0]);
      end
    end
    keys_i[0] = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      tests_run++;
      if (keys_o !== 15'h0020) begin
        tests_failed++;
        $display("FAIL bounce_settle: keys_o=%h, required 0020", keys_o);
      end
    end
  endtask

  task automatic test_release();
    bit found = 0;
    keys_i[5] = 1'b0;
    for (int n = 0; n < 14 && !found; n++) begin
      step();
      if (keys_o[5] === 1'b0) found = 1;
      tests_run++;
      if (release_o !== '0 || press_o !== '0) begin
        tests_failed++;
        $display("FAIL release_early: rel=%h press=%h, required 0000/0000", release_o, press_o);
      end
    end
    tests_run++;
    if (!found || any_key_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_latency: keys_o=%h any=%b, required 0000/0", keys_o, any_key_o);
    end
    step();
    tests_run++;
    if (release_o !== 15'h0020 || press_o !== '0 || num_pressed_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL release_strobe: rel=%h press=%h num=%0d, required 0020/0000/0",
               release_o, press_o, num_pressed_o);
    end
    step();
    tests_run++;
    if (release_o !== '0) begin
      tests_failed++;
      $display("FAIL release_width: release_o=%h, required 0000", release_o);
    end
  endtask

  task automatic test_chord();
    bit found = 0;
    keys_i = 15'h7FFF;
    for (int n = 0; n < 14 && !found; n++) begin
      step();
      if (keys_o !== '0) found = 1;
    end
    tests_run++;
    if (keys_o !== 15'h7FFF) begin
      tests_failed++;
      $display("FAIL chord_level: keys_o=%h, required 7fff", keys_o);
    end
    step();
    tests_run++;
    if (press_o !== 15'h7FFF || num_pressed_o !== 4'd15) begin
      tests_failed++;
      $display("FAIL chord_strobe: press=%h num=%0d, required 7fff/15", press_o, num_pressed_o);
    end
    step();
    tests_run++;
    if (press_o !== '0 || num_pressed_o !== 4'd15) begin
      tests_failed++;
      $display("FAIL chord_hold: press=%h num=%0d, required 0000/15", press_o, num_pressed_o);
    end
    keys_i = '0;
    found  = 0;
    for (int n = 0; n < 14 && !found; n++) begin
      step();
      if (keys_o === '0) found = 1;
    end
    step();
    tests_run++;
    if (release_o !== 15'h7FFF || num_pressed_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL chord_release: rel=%h num=%0d, required 7fff/0", release_o, num_pressed_o);
    end
    repeat (8) step();
  endtask

  task automatic test_reset_mid_count();
    int ticks = 0;
    keys_i[3] = 1'b1;
    for (int n = 0; n < 20 && ticks < 2; n++) begin
      step();
      if (tick_o === 1'b1) ticks++;
    end
    tests_run++;
    if (ticks != 2 || keys_o[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL midcount_pre: ticks=%0d keys_o[3]=%b, required 2/0", ticks, keys_o[3]);
    end
    rst = 1'b1;
    repeat (2) step();
    tests_run++;
    if (keys_o !== '0 || tick_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL midcount_rst: keys_o=%h tick=%b, required 0000/0", keys_o, tick_o);
    end
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      tests_run++;
      if (keys_o[3] !== (j >= 11)) begin
        tests_failed++;
        $display("FAIL midcount_redebounce: cycle %0d keys_o[3]=%b, required %b",
                 j, keys_o[3], j >= 11);
      end
    end
    step();
    tests_run++;
    if (press_o !== 15'h0008 || num_pressed_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL midcount_strobe: press=%h num=%0d, required 0008/1", press_o, num_pressed_o);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_chord();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_key_debounce
`default_nettype wire

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions the raw 15-bit piano keypad before it enters the synth top (piano_keys).
- Each key gets a 2-flop synchroniser, then a debounce filter clocked by a shared sample tick.
- Outputs clean key levels, one-cycle press/release strobes, an any-key flag and a registered count of held keys.
- Removes contact bounce so the key decoder, the octave/mode FSMs and the sequencer see exactly one edge per physical press.

Parameters:
- NUM_KEYS, 15: number of key inputs.
- TICK_DIV, 10000: hwclk cycles per debounce sample tick (1 kHz at 10 MHz).
- STABLE_CNT, 4: consecutive disagreeing ticks required to change a key's state. Legal range is 2..15.
- CNT_W, $clog2(TICK_DIV): width of the prescaler counter (derived, not overridden).

Ports:
- hwclk, input, 1: system clock. The only clock.
- rst, input, 1: synchronous reset, active-high.
- keys_i, input, NUM_KEYS: raw, asynchronous, bouncy key levels (1 = pressed).
- keys_o, output, NUM_KEYS: debounced key levels.
- press_o, output, NUM_KEYS: one-cycle strobe when keys_o[i] goes 0->1.
- release_o, output, NUM_KEYS: one-cycle strobe when keys_o[i] goes 1->0.
- any_key_o, output, 1: OR of keys_o (combinational from keys_o).
- num_pressed_o, output, 4: popcount of keys_o, registered.
- tick_o, output, 1: sample-tick pulse, for debug and bench alignment.

Behaviour:
- Reset: applied on the hwclk edge where rst=1. Clears to 0:
  - both sync stages
  - prescaler
  - all per-key counters
  - keys_o, press_o, release_o, num_pressed_o, tick_o
- Reset mid-bounce discards partial counts. A key held through reset is re-debounced from scratch: STABLE_CNT ticks after rst falls.
- Synchroniser: sync1 <= keys_i; sync2 <= sync1. Only sync2 feeds the filter.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is 1 in the cycle the count equals TICK_DIV-1.
  - tick_o is that value, registered.
- Per-key filter: a counter cnt[i] of width 4. Action on each tick:
  - sync2[i] == keys_o[i]: cnt[i] <= 0.
  - sync2[i] != keys_o[i] and cnt[i] == STABLE_CNT-1: keys_o[i] toggles and cnt[i] <= 0.
  - sync2[i] != keys_o[i] otherwise: cnt[i] <= cnt[i]+1.
- Without a tick, cnt[i] and keys_o[i] hold.
- A single agreeing sample restarts the count, so a glitch shorter than STABLE_CNT ticks never reaches keys_o.
- Strobes:
  - press_o[i] and release_o[i] are registered and asserted in the cycle after keys_o[i] changes.
  - Each is high for exactly one cycle.
  - They are never both high for the same key.
  - Several keys may strobe in the same cycle.
- num_pressed_o is popcount(keys_o) registered, so it lags keys_o by 1 cycle. Maximum value is 15; it never wraps.
- Latency from a clean keys_i edge to keys_o:
  - 2 cycles of synchronisation
  - plus 0..TICK_DIV-1 cycles to the next tick
  - plus (STABLE_CNT-1)*TICK_DIV cycles
  - plus 1 register cycle
- Simultaneous events: keys are fully independent. Every key changing on the same tick is legal and all update together.
- There are no illegal input combinations.

Decomposition:
- sass_pkg holds:
  - NUM_KEYS
  - typedef logic [NUM_KEYS-1:0] keyvec_t
  - default TICK_DIV and STABLE_CNT constants, shared with the std_rate_clk_div-style prescalers
- One sub-module, key_debounce_cell, holds the per-key sync2 bit input, cnt, state and the edge registers. It is instantiated NUM_KEYS times in a generate loop.
- The prescaler, popcount and any_key_o logic stay in the parent.

Test Plan (bench runs with TICK_DIV=4, STABLE_CNT=3):
- Reset then idle: hold rst=1 for 3 cycles, keys_i=0 -> all outputs 0. tick_o pulses every 4 cycles after rst falls.
- Clean press: keys_i[5] 0->1 and held -> keys_o[5]=1 within 2+3+8+1 cycles max. press_o[5] is high for exactly 1 cycle. num_pressed_o=1 one cycle later. any_key_o=1.
- Bounce rejection: keys_i[0] toggles every 3 cycles for 40 cycles, never stable for 3 ticks -> keys_o[0] stays 0 and press_o stays 0.
- Release: from keys_o[5]=1, drop keys_i[5] and hold -> keys_o[5]=0 after the same latency bound. release_o[5] pulses once and press_o[5] stays 0.
- Chord: keys_i=15'h7FFF in one cycle -> all keys_o rise on the same cycle. press_o=15'h7FFF for 1 cycle. num_pressed_o=15.
- Reset mid-count: press keys_i[3] and assert rst after 2 ticks with the key still held -> after rst falls, keys_o[3]=0 until 3 fresh ticks have elapsed.
